// File: rtl/seg_display_reader_if.sv
// Bus bundle between a multiplexed seven-segment display and its reader.
// The master drives the segment/anode lines; the slave returns the decoded digits.
interface seg_display_reader_if #(
    parameter int DIGITS = 4
);
    logic [0:6]          leds;
    logic [DIGITS-1:0]   an;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_valid;
    logic                err;
    logic [2:0]          err_digit;

    modport master (
        output leds,
        output an,
        input  bcd_out,
        input  digit_valid,
        input  frame_valid,
        input  err,
        input  err_digit
    );

    modport slave (
        input  leds,
        input  an,
        output bcd_out,
        output digit_valid,
        output frame_valid,
        output err,
        output err_digit
    );
endinterface

// File: rtl/seg_display_reader.sv
// Reads an active-low multiplexed seven-segment bus back into packed BCD digits.
// Define SEG_READER_HEX_EN to also accept the A..F hex glyphs as legal digits.
module seg_display_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg_display_reader_if.slave  bus
);

    localparam int              SW       = DIGITS + 7;
    localparam logic [3:0]      CNT_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0]      CNT_FIRE = 4'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] ALL_SEEN = {DIGITS{1'b1}};

    // Returns {legal, value}; pattern bit 6 is segment a, bit 0 is segment g.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b0000001: res = {1'b1, 4'd0};
            7'b1001111: res = {1'b1, 4'd1};
            7'b0010010: res = {1'b1, 4'd2};
            7'b0000110: res = {1'b1, 4'd3};
            7'b1001100: res = {1'b1, 4'd4};
            7'b0100100: res = {1'b1, 4'd5};
            7'b0100000: res = {1'b1, 4'd6};
            7'b0001111: res = {1'b1, 4'd7};
            7'b0000000: res = {1'b1, 4'd8};
            7'b0001100: res = {1'b1, 4'd9};
`ifdef SEG_READER_HEX_EN
            7'b0001000: res = {1'b1, 4'd10};
            7'b1100000: res = {1'b1, 4'd11};
            7'b0110001: res = {1'b1, 4'd12};
            7'b1000010: res = {1'b1, 4'd13};
            7'b0110000: res = {1'b1, 4'd14};
            7'b0111000: res = {1'b1, 4'd15};
`else
`endif
            default:    res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    logic [SW-1:0]       r_sync1;
    logic [SW-1:0]       r_s;
    logic [SW-1:0]       r_s_prev;
    logic [3:0]          r_cnt;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_bcd;
    logic [DIGITS-1:0]   r_dv;
    logic                r_frame;
    logic                r_err;
    logic [2:0]          r_err_digit;

    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_leds;
    logic                w_stable;
    logic [3:0]          w_cnt_next;
    logic                w_capture;
    logic [3:0]          w_low_cnt;
    logic [2:0]          w_idx;
    logic                w_qual;
    logic [4:0]          w_dec;
    logic                w_legal;
    logic [3:0]          w_val;
    logic [DIGITS-1:0]   w_sel;
    logic [DIGITS-1:0]   w_seen_upd;
    logic [4*DIGITS-1:0] w_bcd_next;
    logic [DIGITS-1:0]   w_dv_next;
    logic [DIGITS-1:0]   w_seen_next;
    logic                w_frame_next;
    logic                w_err_next;
    logic [2:0]          w_err_digit_next;

    assign w_an    = r_s[SW-1:7];
    assign w_leds  = r_s[6:0];
    assign w_dec   = seg_decode(w_leds);
    assign w_legal = w_dec[4];
    assign w_val   = w_dec[3:0];

    // Stability counter: restarts on any sample change, fires once on reaching the threshold.
    always_comb begin
        w_stable   = (r_s == r_s_prev);
        w_cnt_next = 4'd0;
        w_capture  = 1'b0;
        if (!w_stable) begin
            w_cnt_next = 4'd0;
        end else if (r_cnt >= CNT_MAX) begin
            w_cnt_next = CNT_MAX;
        end else begin
            w_cnt_next = r_cnt + 4'd1;
            w_capture  = (r_cnt == CNT_FIRE);
        end
    end

    // Digit selection: a capture only qualifies when exactly one anode is low.
    always_comb begin
        w_low_cnt = 4'd0;
        w_idx     = 3'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_low_cnt = w_low_cnt + {3'b000, ~w_an[k]};
            if (!w_an[k]) begin
                w_idx = 3'(k);
            end else begin
                w_idx = w_idx;
            end
        end
        w_qual = w_capture && (w_low_cnt == 4'd1);
        w_sel  = w_qual ? ~w_an : {DIGITS{1'b0}};
    end

    // Capture update: legal digits land in their slice, illegal ones invalidate and flag.
    always_comb begin
        w_bcd_next       = r_bcd;
        w_dv_next        = r_dv;
        w_seen_next      = r_seen;
        w_seen_upd       = r_seen | w_sel;
        w_frame_next     = 1'b0;
        w_err_next       = 1'b0;
        w_err_digit_next = r_err_digit;
        if (w_qual) begin
            if (w_legal) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (w_sel[k]) begin
                        w_bcd_next[4*k +: 4] = w_val;
                    end else begin
                        w_bcd_next[4*k +: 4] = r_bcd[4*k +: 4];
                    end
                end
                w_dv_next = r_dv | w_sel;
                if (w_seen_upd == ALL_SEEN) begin
                    w_frame_next = 1'b1;
                    w_seen_next  = {DIGITS{1'b0}};
                end else begin
                    w_seen_next  = w_seen_upd;
                end
            end else begin
                w_dv_next        = r_dv & ~w_sel;
                w_seen_next      = r_seen & ~w_sel;
                w_err_next       = 1'b1;
                w_err_digit_next = w_idx;
            end
        end else begin
            w_seen_next = r_seen;
        end
    end

    // Input synchronizer, previous-sample copy and stability counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= {SW{1'b0}};
            r_s      <= {SW{1'b0}};
            r_s_prev <= {SW{1'b0}};
            r_cnt    <= 4'd0;
        end else begin
            r_sync1  <= {bus.an, bus.leds};
            r_s      <= r_sync1;
            r_s_prev <= r_s;
            r_cnt    <= w_cnt_next;
        end
    end

    // Registered result state and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcd       <= {(4*DIGITS){1'b0}};
            r_dv        <= {DIGITS{1'b0}};
            r_seen      <= {DIGITS{1'b0}};
            r_frame     <= 1'b0;
            r_err       <= 1'b0;
            r_err_digit <= 3'd0;
        end else begin
            r_bcd       <= w_bcd_next;
            r_dv        <= w_dv_next;
            r_seen      <= w_seen_next;
            r_frame     <= w_frame_next;
            r_err       <= w_err_next;
            r_err_digit <= w_err_digit_next;
        end
    end

    assign bus.bcd_out     = r_bcd;
    assign bus.digit_valid = r_dv;
    assign bus.frame_valid = r_frame;
    assign bus.err         = r_err;
    assign bus.err_digit   = r_err_digit;

endmodule

// File: doc/seg_display_reader.md
Name: seg_display_reader

Overview:
- Reads a multiplexed, active-low, seven-segment display bus (segment lines plus per-digit enables) and converts it back to packed BCD digits.
- It is the receiving end of the BCD-to-segment encoding used by the display path.
- Used for loopback self-test of the display driver and for monitoring an external display bus.
- Filters scan glitches with a stability counter, decodes each digit and flags illegal patterns.

Parameters:
DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (2..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
leds  input  [0:6]  segment lines abcdefg, active-low (0 = segment lit)
an  input  [DIGITS-1:0]  digit enables, active-low, one low bit selects a digit
bcd_out  output  [4*DIGITS-1:0]  captured digits; digit i in bits [4i+3:4i]
digit_valid  output  [DIGITS-1:0]  bit i = 1 when bcd_out digit i holds a legally decoded value
frame_valid  output  1  one-cycle pulse when every digit has been captured legally since the previous pulse
err  output  1  one-cycle pulse when an illegal segment pattern is captured
err_digit  output  3  index of the digit that caused the last err; holds until the next err

Behaviour:
- Reset (reset_n low, asynchronous): bcd_out=0, digit_valid=0, frame_valid=0, err=0, err_digit=0; sync registers, stability counter and seen-mask cleared. Operation resumes on the first rising edge after release. A reset mid-scan discards any partial frame.
- Synchronization: {an, leds} passes through a 2-flop synchronizer to produce sample s.
- Stability counter:
  - If s differs from the previous s, counter=0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - Capture fires once, in the cycle the counter reaches STABLE_CYCLES.
  - Latency from the inputs settling to the bcd_out/err update is exactly STABLE_CYCLES+3 edges.
- Capture qualification: an must have exactly one low bit, and its index must be < DIGITS.
  - If an is all-high (blank) or has more than one low bit, nothing is captured and no error is raised.
- Decode (leds, active-low abcdefg):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9
- Legal capture for digit i:
  - Write the digit into bcd_out slice i and set digit_valid[i].
  - Set seen[i].
- Illegal capture for digit i:
  - bcd_out slice i is unchanged; clear digit_valid[i] and seen[i].
  - err=1 for one cycle; err_digit=i.
- Frame completion:
  - When seen becomes all-ones, pulse frame_valid for one cycle and clear seen in the same cycle.
  - Digit capture order is irrelevant.
  - Recapturing the same digit before the frame completes overwrites it; it does not count twice.
- Simultaneous events: a legal capture that completes a frame produces the bcd_out update and the frame_valid pulse on the same edge. err and frame_valid are mutually exclusive because a capture is a single event.
- A pattern held indefinitely is captured only once, until s changes.

Optional Feature:
- Macro SEG_READER_HEX_EN.
- When defined, the following patterns also decode legally: 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F (values 10..15).
- When not defined, these patterns are illegal and raise err.

Test Plan:
- Reset: assert reset_n=0 mid-capture -> all outputs 0 immediately. Release, drive an=1110, leds=0010010 steady -> after 7 edges bcd_out[3:0]=2, digit_valid=0001, err=0.
- Full frame: scan digits 0..3 with 1,2,3,4 (each held 10 cycles, separated by blanks an=1111) -> bcd_out=16'h4321, digit_valid=1111, one frame_valid pulse after the digit-3 capture.
- Glitch filter: digit 1 shows 0000000 for 2 cycles, then 1001111 held -> only value 1 is captured; no 8 appears and err=0.
- Illegal pattern: an=1011, leds=1111110 held -> err pulses once, err_digit=2, digit_valid[2]=0, slice 2 keeps its prior value, no frame_valid.
- Ghosting and hold: an=1100 with a legal pattern -> no capture, no err. A legal digit held 100 cycles -> exactly one capture.
- Hex: leds=0001000 on digit 0 -> with SEG_READER_HEX_EN, bcd_out[3:0]=4'hA and no err; without it, err=1 and err_digit=0.
